// File: rtl/strike_tracker_if.sv
// Strike tracker bus: puzzle-side requests in, game-status outputs back out.
interface strike_tracker_if #(
  parameter int N_SRC       = 6,
  parameter int MAX_STRIKES = 3,
  parameter int CNT_W       = 3
);
  logic                   arm;
  logic                   defuse;
  logic [N_SRC-1:0]       strike;
  logic [CNT_W-1:0]       strike_count;
  logic [MAX_STRIKES-1:0] strike_led;
  logic                   strike_pulse;
  logic                   explode;
  logic                   defused;

  modport master (
    output arm, defuse, strike,
    input  strike_count, strike_led, strike_pulse, explode, defused
  );

  modport slave (
    input  arm, defuse, strike,
    output strike_count, strike_led, strike_pulse, explode, defused
  );
endinterface

// File: rtl/strike_tracker.sv
// Edge-detecting, saturating strike counter with an idle/armed/exploded/defused game FSM.
// Optional newest-LED blink and explosion flashing: define STRIKE_FLASH_EN.
module strike_tracker #(
  parameter int N_SRC       = 6,
  parameter int MAX_STRIKES = 3,
  parameter int CNT_W       = 3,
  parameter int FLASH_HALF  = 13_500_000
) (
  input logic            clock,
  input logic            reset_n,
  strike_tracker_if.slave bus
);
  localparam int WIDE_W = CNT_W + 5;
  localparam logic [WIDE_W-1:0] MAX_W = WIDE_W'(MAX_STRIKES);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_STRIKES);

  if (N_SRC < 1 || MAX_STRIKES < 1 || (2 ** CNT_W) <= MAX_STRIKES || FLASH_HALF < 1) begin : g_param_check
    $error("strike_tracker: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODED, DEFUSED} state_t;

  state_t                 state, state_nxt;
  logic [N_SRC-1:0]       strike_q;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [WIDE_W-1:0]      new_edges, sum_sat;
  logic                   pulse_nxt, pulse_q;
  logic [MAX_STRIKES-1:0] therm_nxt, led_nxt, led_q;
  logic                   explode_q, defused_q;

  function automatic logic [WIDE_W-1:0] popcount(input logic [N_SRC-1:0] v);
    logic [WIDE_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_SRC; i++) n = n + WIDE_W'(v[i]);
    return n;
  endfunction

  function automatic logic [WIDE_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [WIDE_W-1:0] n);
    logic [WIDE_W-1:0] s;
    s = WIDE_W'(c) + n;
    return (s > MAX_W) ? MAX_W : s;
  endfunction

  function automatic logic [MAX_STRIKES-1:0] thermometer(input logic [CNT_W-1:0] c);
    logic [MAX_STRIKES-1:0] t;
    for (int i = 0; i < MAX_STRIKES; i++) t[i] = (c > CNT_W'(i));
    return t;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    new_edges = popcount(bus.strike & ~strike_q);
    sum_sat   = sat_add(count, new_edges);
    state_nxt = state;
    case (state)
      IDLE:    if (bus.arm) state_nxt = ARMED;
      // The final strike beats a simultaneous defuse.
      ARMED:   if (sum_sat == MAX_W) state_nxt = EXPLODED;
               else if (bus.defuse) state_nxt = DEFUSED;
      default: ;
    endcase
  end

  always_comb begin
    count_nxt = count;
    pulse_nxt = 1'b0;
    case (state)
      IDLE:    if (bus.arm) count_nxt = '0;
      ARMED: begin
        count_nxt = sum_sat[CNT_W-1:0];
        pulse_nxt = (new_edges != '0) && (count < MAX_C);
      end
      default: ;
    endcase
    therm_nxt = thermometer(count_nxt);
  end

`ifdef STRIKE_FLASH_EN
  localparam int TMR_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(FLASH_HALF - 1);

  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [2:0]       halves, halves_nxt;
  logic             dark, dark_nxt;

  // dark blanks the newest LED (ARMED) or every LED (EXPLODED); halves counts blink phases left.
  always_comb begin
    tmr_nxt    = tmr;
    halves_nxt = halves;
    dark_nxt   = dark;
    if (state == EXPLODED) begin
      if (tmr == '0) begin
        dark_nxt = ~dark;
        tmr_nxt  = TMR_RELOAD;
      end else begin
        tmr_nxt  = tmr - TMR_W'(1);
      end
    end else if (state != ARMED || state_nxt != ARMED) begin
      tmr_nxt    = '0;
      halves_nxt = '0;
      dark_nxt   = 1'b0;
    end else if (pulse_nxt) begin
      tmr_nxt    = '0;
      halves_nxt = 3'd6;
      dark_nxt   = 1'b0;
    end else if (halves != '0 || tmr != '0) begin
      if (tmr == '0) begin
        dark_nxt   = ~dark;
        tmr_nxt    = TMR_RELOAD;
        halves_nxt = halves - 3'd1;
      end else begin
        tmr_nxt    = tmr - TMR_W'(1);
      end
    end

    if (!dark_nxt)                   led_nxt = therm_nxt;
    else if (state_nxt == EXPLODED)  led_nxt = '0;
    else                             led_nxt = therm_nxt & (therm_nxt >> 1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmr    <= '0;
      halves <= '0;
      dark   <= 1'b0;
    end else begin
      tmr    <= tmr_nxt;
      halves <= halves_nxt;
      dark   <= dark_nxt;
    end
  end
`else
  always_comb led_nxt = therm_nxt;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strike_q  <= '0;
      count     <= '0;
      pulse_q   <= 1'b0;
      led_q     <= '0;
      explode_q <= 1'b0;
      defused_q <= 1'b0;
    end else begin
      strike_q  <= bus.strike;
      count     <= count_nxt;
      pulse_q   <= pulse_nxt;
      led_q     <= led_nxt;
      explode_q <= (state_nxt == EXPLODED);
      defused_q <= (state_nxt == DEFUSED);
    end
  end

  assign bus.strike_count = count;
  assign bus.strike_led   = led_q;
  assign bus.strike_pulse = pulse_q;
  assign bus.explode      = explode_q;
  assign bus.defused      = defused_q;
endmodule

// File: tb/tb_strike_tracker.sv
// Randomised and directed bench for strike_tracker against a behavioural game model.
module tb_strike_tracker;
  localparam int N_SRC = 4;
  localparam int MAXS  = 3;
  localparam int CW    = 2;
  localparam int FH    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  strike_tracker_if #(.N_SRC(N_SRC), .MAX_STRIKES(MAXS), .CNT_W(CW)) bif ();

  strike_tracker #(.N_SRC(N_SRC), .MAX_STRIKES(MAXS), .CNT_W(CW), .FLASH_HALF(FH)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bif)
  );

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;

  // Game model: 0 idle, 1 armed, 2 exploded, 3 defused.
  int         m_phase, m_cnt, m_edge, m_inc_edge, m_exp_edge;
  logic [3:0] m_prev;
  bit         m_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_led();
    logic [2:0] t;
    int d;
    t = 3'((1 << m_cnt) - 1);
`ifdef STRIKE_FLASH_EN
    if (m_phase == 2) begin
      d = m_edge - m_exp_edge - 1;
      if (d >= 0 && (d / FH) % 2 == 0) t = 3'b000;
    end else if (m_phase == 1 && m_cnt > 0) begin
      d = m_edge - m_inc_edge - 1;
      if (d >= 0 && d / FH < 6 && (d / FH) % 2 == 0) t = t & ~3'(1 << (m_cnt - 1));
    end
`endif
    return t;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_cnt = 0; m_prev = '0; m_pulse = 0;
        m_edge = 0; m_inc_edge = -1000; m_exp_edge = -1000;
      end else begin
        int rises;
        m_edge++;
        rises = $countones(bif.strike & ~m_prev);
        m_pulse = 0;
        if (m_phase == 0) begin
          if (bif.arm) begin m_phase = 1; m_cnt = 0; end
        end else if (m_phase == 1) begin
          m_pulse = (rises > 0) && (m_cnt < MAXS);
          m_cnt = (m_cnt + rises > MAXS) ? MAXS : m_cnt + rises;
          if (m_pulse) m_inc_edge = m_edge;
          if (m_cnt == MAXS) begin m_phase = 2; m_exp_edge = m_edge; end
          else if (bif.defuse) m_phase = 3;
        end
        m_prev = bif.strike;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bif.strike_pulse === 1'b1) pulses++;
      chk("count", 32'(bif.strike_count), 32'(m_cnt));
      chk("led", 32'(bif.strike_led), 32'(exp_led()));
      chk("pulse", 32'(bif.strike_pulse), 32'(m_pulse));
      chk("explode", 32'(bif.explode), 32'(m_phase == 2));
      chk("defused", 32'(bif.defused), 32'(m_phase == 3));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic drive(input bit a, input bit d, input logic [3:0] s);
    bif.arm = a; bif.defuse = d; bif.strike = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; drive(0, 0, 4'b0000); step(2); rst_n = 1'b1; step();
  endtask

  task automatic arm_game();
    drive(1, 0, bif.strike); step(); bif.arm = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 4'b0000);
    step(3);
    chk("reset_count", 32'(bif.strike_count), 32'd0);
    chk("reset_explode", 32'(bif.explode), 32'd0);
    rst_n = 1'b1; step();

    // Pulse then long hold: counted once each.
    arm_game();
    pulses = 0;
    bif.strike = 4'b0001; step();
    chk("s1_count1", 32'(bif.strike_count), 32'd1);
    chk("s1_model1", 32'(m_cnt), 32'd1);
    bif.strike = 4'b0010; step();
    chk("s1_count2", 32'(bif.strike_count), 32'd2);
    step(19);
    chk("s1_hold_count", 32'(bif.strike_count), 32'd2);
`ifndef STRIKE_FLASH_EN
    chk("s1_led", 32'(bif.strike_led), 32'b011);
`endif
    chk("s1_pulses", 32'(pulses), 32'd2);
    chk("s1_explode", 32'(bif.explode), 32'd0);

    // Three simultaneous strikes explode at once.
    do_reset(); arm_game(); pulses = 0;
    bif.strike = 4'b0111; step();
    chk("s2_count", 32'(bif.strike_count), 32'd3);
    chk("s2_led", 32'(bif.strike_led), 32'b111);
    chk("s2_pulse", 32'(bif.strike_pulse), 32'd1);
    chk("s2_explode", 32'(bif.explode), 32'd1);
    chk("s2_model", 32'(m_phase), 32'd2);
    bif.strike = 4'b0000; step();
    bif.strike = 4'b1000; step(2);
    chk("s2_after_count", 32'(bif.strike_count), 32'd3);
    chk("s2_after_pulses", 32'(pulses), 32'd1);

    // A line already high at arm is not counted until re-raised.
    do_reset();
    bif.strike = 4'b0001; step();
    arm_game(); step(3);
    chk("s3_held", 32'(bif.strike_count), 32'd0);
    bif.strike = 4'b0000; step();
    bif.strike = 4'b0001; step();
    chk("s3_reraise", 32'(bif.strike_count), 32'd1);

    // Final strike and defuse together: strike wins.
    do_reset(); arm_game();
    bif.strike = 4'b0001; step(); bif.strike = 4'b0000; step();
    bif.strike = 4'b0010; step(); bif.strike = 4'b0000; step();
    drive(0, 1, 4'b0100); step();
    chk("s4_explode", 32'(bif.explode), 32'd1);
    chk("s4_defused", 32'(bif.defused), 32'd0);
    do_reset(); arm_game();
    bif.strike = 4'b0001; step(); bif.strike = 4'b0011; step();
    drive(0, 1, 4'b0011); step();
    chk("s4b_defused", 32'(bif.defused), 32'd1);
    chk("s4b_count", 32'(bif.strike_count), 32'd2);
`ifndef STRIKE_FLASH_EN
    chk("s4b_led", 32'(bif.strike_led), 32'b011);
`endif
    bif.defuse = 1'b0;

    // Asynchronous reset between edges, then strikes without arm.
    do_reset(); arm_game();
    bif.strike = 4'b0001; step(); bif.strike = 4'b0011; step();
    chk("s5_pre", 32'(bif.strike_count), 32'd2);
    rst_n = 1'b0; #1;
    chk("s5_async_count", 32'(bif.strike_count), 32'd0);
    chk("s5_async_led", 32'(bif.strike_led), 32'd0);
    chk("s5_async_flags", {29'd0, bif.strike_pulse, bif.explode, bif.defused}, 32'd0);
    step(); rst_n = 1'b1;
    bif.strike = 4'b0000; step(); bif.strike = 4'b1111; step(2);
    chk("s5_no_arm", 32'(bif.strike_count), 32'd0);

`ifdef STRIKE_FLASH_EN
    begin
      logic [23:0] pat;
      pat = 24'b1111_0000_1111_0000_1111_0000;
      do_reset(); arm_game();
      bif.strike = 4'b0001; step();
      chk("fl_first", 32'(bif.strike_led), 32'b001);
      bif.strike = 4'b0000;
      for (int j = 0; j < 24; j++) begin step(); chk("fl_blink", 32'(bif.strike_led[0]), 32'(pat[j])); end
      step(4);
      chk("fl_solid", 32'(bif.strike_led), 32'b001);
      bif.strike = 4'b0110; step();
      chk("fl_exp", 32'(bif.strike_led), 32'b111);
      for (int j = 1; j <= 8; j++) begin step(); chk("fl_exp_blink", 32'(bif.strike_led), (j <= 4) ? 32'b000 : 32'b111); end
    end
`endif

    // Randomised play; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(59) != 0);
      bif.arm = ($urandom_range(9) == 0);
      bif.defuse = ($urandom_range(39) == 0);
      if ($urandom_range(2) == 0) bif.strike = 4'($urandom);
      step();
    end
    rst_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
